// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and encodings for the memory bus master
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ADDR   = 2'b01,
    ACCESS = 2'b10,
    DONE   = 2'b11
  } state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  function automatic logic funct3_valid(input logic is_store, input logic [2:0] funct3);
    if (is_store)
      return funct3 inside {SB, SH, SW};
    else
      return funct3 inside {LB, LH, LW, LBU, LHU};
  endfunction

  // Width is carried by funct3[1:0]; bit 2 only selects zero-extension on loads.
  function automatic logic [1:0] data_size(input logic [1:0] funct3_width);
    case (funct3_width)
      2'b00:   return SIZE_BYTE;
      2'b01:   return SIZE_HALF;
      default: return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_extender.sv
// rtl/load_extender.sv - sign/zero extension of raw load data by funct3
module load_extender
  import mem_bus_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw_data,
  output logic [31:0] ext_data
);

  always_comb begin
    ext_data = raw_data;
    case (funct3)
      LB:      ext_data = {{24{raw_data[7]}}, raw_data[7:0]};
      LBU:     ext_data = {24'd0, raw_data[7:0]};
      LH:      ext_data = {{16{raw_data[15]}}, raw_data[15:0]};
      LHU:     ext_data = {16'd0, raw_data[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - single-outstanding load/store master for an address-then-data memory bus
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_address,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  bus_write_address,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic                  bus_read,
  output logic                  bus_write,
  output logic [1:0]            bus_data_size,
  output logic [31:0]           bus_data_out,
  output logic                  bus_data_oe,
  input  logic [31:0]           bus_data_in
);

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    r_write;
  logic [2:0]              r_funct3;
  logic [ADDR_WIDTH-1:0]   r_address;
  logic [31:0]             r_wdata;
  logic [31:0]             r_rdata;
  logic                    r_error;
  logic                    w_accept;
  logic                    w_req_error;
  logic [31:0]             w_ext_data;

  // Kept outside the FSM block so w_accept does not loop back through it.
  assign req_ready   = (r_state == IDLE) && reset;
  assign w_accept    = req_valid && req_ready;
  assign w_req_error = !funct3_valid(req_write, req_funct3) ||
                       ((req_address >> ADDR_WIDTH) != 32'd0);

  load_extender u_load_extender (
    .funct3   (r_funct3),
    .raw_data (bus_data_in),
    .ext_data (w_ext_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_write   <= 1'b0;
      r_funct3  <= 3'd0;
      r_address <= '0;
      r_wdata   <= 32'd0;
      r_rdata   <= 32'd0;
      r_error   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_write   <= req_write;
        r_funct3  <= req_funct3;
        r_address <= req_address[ADDR_WIDTH-1:0];
        r_wdata   <= req_wdata;
        r_error   <= w_req_error;
      end
      if ((r_state == ACCESS) && !r_write) begin
        r_rdata <= w_ext_data;
      end
    end
  end

  always_comb begin
    w_next_state      = r_state;
    resp_valid        = 1'b0;
    resp_rdata        = 32'd0;
    resp_error        = 1'b0;
    bus_write_address = 1'b0;
    bus_address       = '0;
    bus_read          = 1'b0;
    bus_write         = 1'b0;
    bus_data_size     = SIZE_BYTE;
    bus_data_out      = 32'd0;
    bus_data_oe       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = w_req_error ? DONE : ADDR;
        end
      end
      ADDR: begin
        bus_write_address = 1'b1;
        bus_address       = r_address;
        w_next_state      = ACCESS;
      end
      ACCESS: begin
        bus_data_size = data_size(r_funct3[1:0]);
        if (r_write) begin
          bus_write    = 1'b1;
          bus_data_oe  = 1'b1;
          bus_data_out = r_wdata;
        end else begin
          bus_read = 1'b1;
        end
        w_next_state = DONE;
      end
      DONE: begin
        resp_valid   = 1'b1;
        resp_error   = r_error;
        resp_rdata   = (r_error || r_write) ? 32'd0 : r_rdata;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - self-checking bench for mem_bus_master
module tb_mem_bus_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        bus_write_address, bus_read, bus_write, bus_data_oe;
  logic [15:0] bus_address;
  logic [1:0]  bus_data_size;
  logic [31:0] bus_data_out, bus_data_in;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_bus_master #(.ADDR_WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_address(req_address), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .bus_write_address(bus_write_address), .bus_address(bus_address),
    .bus_read(bus_read), .bus_write(bus_write), .bus_data_size(bus_data_size),
    .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe), .bus_data_in(bus_data_in)
  );

  // Bus-side memory: latches the address pulse, little-endian byte lanes.
  logic [7:0]  mem [0:65535];
  logic [15:0] m_addr = 16'd0;
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = 16'd0;
  logic [7:0]  pl_data = 8'd0;

  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (bus_write_address) m_addr <= bus_address;
    if (bus_write) begin
      for (int i = 0; i < 4; i++) begin
        if (i < ((bus_data_size == 2'b11) ? 4 : (bus_data_size == 2'b01) ? 2 : 1))
          mem[16'(m_addr + 16'(i))] <= bus_data_out[8*i +: 8];
      end
    end
  end

  assign bus_data_in = {mem[m_addr + 16'd3], mem[m_addr + 16'd2], mem[m_addr + 16'd1], mem[m_addr]};

  // Reference model: byte array plus arithmetic extension rules.
  logic [7:0] ref_mem [0:65535];

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [15:0] a);
    longint b0 = ref_mem[a];
    longint b1 = ref_mem[16'(a + 16'd1)];
    longint b2 = ref_mem[16'(a + 16'd2)];
    longint b3 = ref_mem[16'(a + 16'd3)];
    longint v;
    case (f3)
      3'b000:  begin v = b0; if (v >= 128) v -= 256; end
      3'b100:  v = b0;
      3'b001:  begin v = b0 + 256 * b1; if (v >= 32768) v -= 65536; end
      3'b101:  v = b0 + 256 * b1;
      default: v = b0 + 256 * b1 + 65536 * b2 + 16777216 * b3;
    endcase
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [15:0] a, input logic [31:0] wd);
    int n;
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) ref_mem[16'(a + 16'(i))] = 8'((wd >> (8 * i)) & 32'hFF);
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] b);
    @(negedge clock);
    pl_en = 1'b1; pl_addr = a; pl_data = b;
    ref_mem[a] = b;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clock);
      checks++;
      if ((bus_read && bus_write) || (bus_data_oe && !bus_write) ||
          (!bus_write_address && bus_address != 16'd0) || (!bus_data_oe && bus_data_out != 32'd0) ||
          (!resp_valid && (resp_rdata != 32'd0 || resp_error)) || (bus_data_size == 2'b10) ||
          (req_ready && (bus_read || bus_write || bus_write_address || resp_valid))) begin
        errors++;
        $display("FAIL bus_invariant at %0t: rd=%b wr=%b oe=%b wa=%b addr=%h dout=%h rv=%b rdata=%h re=%b size=%b ready=%b required exclusive strobes and idle zeros",
                 $time, bus_read, bus_write, bus_data_oe, bus_write_address, bus_address, bus_data_out,
                 resp_valid, resp_rdata, resp_error, bus_data_size, req_ready);
      end
      if (!reset) begin
        checks++;
        if ({req_ready, resp_valid, resp_rdata, resp_error, bus_write_address, bus_address, bus_read,
             bus_write, bus_data_size, bus_data_out, bus_data_oe} != '0) begin
          errors++;
          $display("FAIL reset_outputs at %0t: outputs nonzero while reset low, required all 0", $time);
        end
      end
    end
  endtask

  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er, output int n_resp,
                         output int n_wa, output int n_rd, output int n_wr, output int n_oe,
                         output logic [15:0] wa_addr, output logic [1:0] sz);
    int guard;
    lat = 0; rd = 32'd0; er = 1'b0; n_resp = 0; n_wa = 0; n_rd = 0; n_wr = 0; n_oe = 0;
    wa_addr = 16'd0; sz = 2'b00;
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_address = a; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready=%b required 1 within 10 cycles", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 1) begin
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_address = 32'd0; req_wdata = 32'd0;
      end
      if (bus_write_address) begin n_wa++; wa_addr = bus_address; end
      if (bus_read) n_rd++;
      if (bus_write) n_wr++;
      if (bus_data_oe) n_oe++;
      if (bus_read || bus_write) sz = bus_data_size;
      if (resp_valid) begin
        n_resp++;
        if (lat == 0) begin lat = k; rd = resp_rdata; er = resp_error; end
      end
    end
  endtask

  int lat, n_resp, n_wa, n_rd, n_wr, n_oe;
  logic [31:0] rd;
  logic er;
  logic [15:0] wa_addr;
  logic [1:0] sz;

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_address = 32'd0; req_wdata = 32'd0;
    repeat (2) @(negedge clock);
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || bus_read !== 1'b0 || bus_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b rv=%b rd=%b wr=%b required all 0", req_ready, resp_valid, bus_read, bus_write);
    end
    preload(16'h0010, 8'h78); preload(16'h0011, 8'h56);
    preload(16'h0012, 8'h34); preload(16'h0013, 8'h12);
    for (int i = 16'h0100; i < 16'h0144; i++) preload(16'(i), 8'($urandom));
    @(negedge clock);
    pl_en = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_lw();
    run_req(1'b0, 3'b010, 32'h0000_0010, 32'd0, lat, rd, er, n_resp, n_wa, n_rd, n_wr, n_oe, wa_addr, sz);
    checks++;
    if (lat != 3 || rd !== 32'h1234_5678 || er !== 1'b0 || n_resp != 1) begin
      errors++;
      $display("FAIL lw_resp: lat=%0d rdata=%h err=%b pulses=%0d required lat=3 rdata=12345678 err=0 pulses=1", lat, rd, er, n_resp);
    end
    checks++;
    if (n_wa != 1 || wa_addr !== 16'h0010 || n_rd != 1 || n_wr != 0 || sz !== 2'b11) begin
      errors++;
      $display("FAIL lw_bus: wa=%0d addr=%h rd=%0d wr=%0d size=%b required 1 0010 1 0 11", n_wa, wa_addr, n_rd, n_wr, sz);
    end
  endtask

  task automatic test_byte();
    run_req(1'b1, 3'b000, 32'h0000_0020, 32'hAABB_CC80, lat, rd, er, n_resp, n_wa, n_rd, n_wr, n_oe, wa_addr, sz);
    ref_store(3'b000, 16'h0020, 32'hAABB_CC80);
    checks++;
    if (lat != 3 || rd !== 32'd0 || er !== 1'b0 || n_wr != 1 || n_oe != 1 || n_rd != 0 || sz !== 2'b00) begin
      errors++;
      $display("FAIL sb_store: lat=%0d rdata=%h err=%b wr=%0d oe=%0d rd=%0d size=%b required 3 0 0 1 1 0 00", lat, rd, er, n_wr, n_oe, n_rd, sz);
    end
    run_req(1'b0, 3'b000, 32'h0000_0020, 32'd0, lat, rd, er, n_resp, n_wa, n_rd, n_wr, n_oe, wa_addr, sz);
    checks++;
    if (rd !== 32'hFFFF_FF80 || n_oe != 0 || sz !== 2'b00 || lat != 3) begin
      errors++;
      $display("FAIL lb_load: rdata=%h oe=%0d size=%b lat=%0d required FFFFFF80 0 00 3", rd, n_oe, sz, lat);
    end
    run_req(1'b0, 3'b100, 32'h0000_0020, 32'd0, lat, rd, er, n_resp, n_wa, n_rd, n_wr, n_oe, wa_addr, sz);
    checks++;
    if (rd !== 32'h0000_0080 || n_oe != 0 || sz !== 2'b00) begin
      errors++;
      $display("FAIL lbu_load: rdata=%h oe=%0d size=%b required 00000080 0 00", rd, n_oe, sz);
    end
  endtask

  task automatic test_misaligned();
    run_req(1'b1, 3'b001, 32'h0000_0031, 32'h0000_8001, lat, rd, er, n_resp, n_wa, n_rd, n_wr, n_oe, wa_addr, sz);
    ref_store(3'b001, 16'h0031, 32'h0000_8001);
    checks++;
    if (er !== 1'b0 || wa_addr !== 16'h0031 || sz !== 2'b01 || lat != 3) begin
      errors++;
      $display("FAIL sh_misaligned: err=%b addr=%h size=%b lat=%0d required 0 0031 01 3", er, wa_addr, sz, lat);
    end
    run_req(1'b0, 3'b001, 32'h0000_0031, 32'd0, lat, rd, er, n_resp, n_wa, n_rd, n_wr, n_oe, wa_addr, sz);
    checks++;
    if (rd !== 32'hFFFF_8001 || er !== 1'b0) begin
      errors++;
      $display("FAIL lh_misaligned: rdata=%h err=%b required FFFF8001 0", rd, er);
    end
    run_req(1'b0, 3'b101, 32'h0000_0031, 32'd0, lat, rd, er, n_resp, n_wa, n_rd, n_wr, n_oe, wa_addr, sz);
    checks++;
    if (rd !== 32'h0000_8001 || er !== 1'b0) begin
      errors++;
      $display("FAIL lhu_misaligned: rdata=%h err=%b required 00008001 0", rd, er);
    end
  endtask

  task automatic test_errors();
    run_req(1'b0, 3'b011, 32'h0000_0040, 32'd0, lat, rd, er, n_resp, n_wa, n_rd, n_wr, n_oe, wa_addr, sz);
    checks++;
    if (lat != 1 || er !== 1'b1 || rd !== 32'd0 || n_resp != 1 || (n_wa + n_rd + n_wr + n_oe) != 0) begin
      errors++;
      $display("FAIL err_funct3: lat=%0d err=%b rdata=%h pulses=%0d strobes=%0d required 1 1 0 1 0", lat, er, rd, n_resp, n_wa + n_rd + n_wr + n_oe);
    end
    run_req(1'b0, 3'b010, 32'h0001_0000, 32'd0, lat, rd, er, n_resp, n_wa, n_rd, n_wr, n_oe, wa_addr, sz);
    checks++;
    if (lat != 1 || er !== 1'b1 || rd !== 32'd0 || (n_wa + n_rd + n_wr + n_oe) != 0) begin
      errors++;
      $display("FAIL err_address: lat=%0d err=%b rdata=%h strobes=%0d required 1 1 0 0", lat, er, rd, n_wa + n_rd + n_wr + n_oe);
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_address = 32'h0000_0050; req_wdata = 32'hDEAD_BEEF;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready: req_ready=%b required 1", req_ready);
    end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (bus_write !== 1'b1 || bus_data_oe !== 1'b1) begin
      errors++;
      $display("FAIL abort_precondition: wr=%b oe=%b required 1 1", bus_write, bus_data_oe);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus_write !== 1'b0 || bus_data_oe !== 1'b0 || bus_data_out !== 32'd0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: wr=%b oe=%b dout=%h ready=%b required 0 0 0 0", bus_write, bus_data_oe, bus_data_out, req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_resp: resp_valid=%b required 0", resp_valid);
      end
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_release_ready: req_ready=%b required 1", req_ready);
    end
    run_req(1'b0, 3'b010, 32'h0000_0010, 32'd0, lat, rd, er, n_resp, n_wa, n_rd, n_wr, n_oe, wa_addr, sz);
    checks++;
    if (lat != 3 || rd !== 32'h1234_5678 || er !== 1'b0) begin
      errors++;
      $display("FAIL abort_next_lw: lat=%0d rdata=%h err=%b required 3 12345678 0", lat, rd, er);
    end
  endtask

  task automatic test_back_to_back();
    int acc[3];
    int n, nresp;
    logic drop;
    n = 0; nresp = 0; drop = 1'b0;
    acc = '{0, 0, 0};
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h0000_0010; req_wdata = 32'd0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clock);
      if (drop) begin req_valid = 1'b0; drop = 1'b0; end
      if (resp_valid) begin
        nresp++;
        checks++;
        if (resp_rdata !== 32'h1234_5678) begin
          errors++;
          $display("FAIL b2b_rdata: rdata=%h required 12345678", resp_rdata);
        end
      end
      if (req_valid && req_ready && n < 3) begin
        acc[n] = c;
        n++;
        if (n == 3) drop = 1'b1;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (n != 3 || nresp != 3 || (acc[1] - acc[0]) != 4 || (acc[2] - acc[1]) != 4) begin
      errors++;
      $display("FAIL b2b_spacing: accepts=%0d resps=%0d gaps=%0d,%0d required 3 3 4,4", n, nresp, acc[1] - acc[0], acc[2] - acc[1]);
    end
  endtask

  task automatic test_random();
    logic        w, valid;
    logic [2:0]  f3;
    logic [31:0] a, wd, exp_rd;
    logic [1:0]  exp_sz;
    int          nb;
    for (int t = 0; t < 40; t++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      a  = 32'h0000_0100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(16, 31));
      valid = (a[31:16] == 16'd0) && (w ? (f3 <= 3'd2) : (f3 <= 3'd5 && f3 != 3'd3));
      run_req(w, f3, a, wd, lat, rd, er, n_resp, n_wa, n_rd, n_wr, n_oe, wa_addr, sz);
      if (!valid) begin
        checks++;
        if (lat != 1 || er !== 1'b1 || rd !== 32'd0 || n_resp != 1 || (n_wa + n_rd + n_wr + n_oe) != 0) begin
          errors++;
          $display("FAIL rand_err[%0d] w=%b f3=%0d a=%h: lat=%0d err=%b rdata=%h strobes=%0d required 1 1 0 0", t, w, f3, a, lat, er, rd, n_wa + n_rd + n_wr + n_oe);
        end
      end else begin
        nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        exp_sz = (nb == 1) ? 2'b00 : (nb == 2) ? 2'b01 : 2'b11;
        exp_rd = w ? 32'd0 : ref_load(f3, a[15:0]);
        checks++;
        if (lat != 3 || er !== 1'b0 || rd !== exp_rd || n_resp != 1) begin
          errors++;
          $display("FAIL rand_resp[%0d] w=%b f3=%0d a=%h: lat=%0d err=%b rdata=%h required 3 0 %h", t, w, f3, a, lat, er, rd, exp_rd);
        end
        checks++;
        if (n_wa != 1 || wa_addr !== a[15:0] || n_rd != int'(!w) || n_wr != int'(w) || n_oe != int'(w) || sz !== exp_sz) begin
          errors++;
          $display("FAIL rand_bus[%0d] w=%b f3=%0d: wa=%0d addr=%h rd=%0d wr=%0d oe=%0d size=%b required addr=%h size=%b", t, w, f3, n_wa, wa_addr, n_rd, n_wr, n_oe, sz, a[15:0], exp_sz);
        end
        if (w) ref_store(f3, a[15:0], wd);
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_lw();
    test_byte();
    test_misaligned();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
